// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC and issues one outstanding read at a time.
// Define FETCH_COUNT_EN to add the accepted-instruction counter and fetch_count port.
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] INC        = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic        mem_rbusy,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        halt
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rstrb_q, mem_rstrb_d;
  logic        launch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    instr_d = instr_q;
    launch  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!halt) launch = 1'b1;
      end
      StReq: begin
        // REQ without a strobe only happens straight out of reset
        if (!mem_rstrb_q) begin
          launch = 1'b1;
        end else begin
          state_d = StWait;
          if (redirect_valid) flush_d = 1'b1;
        end
      end
      StWait: begin
        if (!mem_rbusy) begin
          if (flush_q || redirect_valid) begin
            flush_d = 1'b0;
            launch  = 1'b1;
          end else begin
            instr_d = mem_rdata;
            pc_d    = pc_q + INC;
            state_d = StHold;
          end
        end else if (redirect_valid) begin
          flush_d = 1'b1;
        end
      end
      StHold: begin
        if (instr_ready || redirect_valid) launch = 1'b1;
      end
      default: state_d = StReq;
    endcase
    if (redirect_valid) pc_d = redirect_addr;
    if (launch) state_d = halt ? StIdle : StReq;
  end

  // Address is captured only when a request is launched so it stays put while outstanding
  always_comb begin
    mem_rstrb_d   = (state_d == StReq);
    instr_valid_d = (state_d == StHold);
    mem_addr_d    = (state_d == StReq) ? pc_d : mem_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StReq;
      pc_q          <= RESET_ADDR;
      flush_q       <= 1'b0;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      mem_addr_q    <= RESET_ADDR;
      mem_rstrb_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_rstrb_q   <= mem_rstrb_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rstrb   = mem_rstrb_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

`ifdef FETCH_COUNT_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == StHold && instr_ready) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= 32'h0;
    else       count_q <= count_d;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: transaction-level reference model, directed scenarios
// followed by randomized memory latency, decode backpressure, halts, redirects and resets.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic        mem_rbusy;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        halt;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_rstrb      (mem_rstrb),
    .mem_rbusy      (mem_rbusy),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt           (halt)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int          lat   = 0;   // extra busy cycles per read; -1 = random
  int          lag   = 0;   // HOLD cycles before accept; -1 = random ready
  int unsigned st_cyc[$];
  logic [31:0] st_addr[$];

  // Reference model: what the fetch stream must look like, tracked per transaction
  bit          m_strobe, m_busy, m_stale, m_valid, m_parked;
  logic [31:0] m_pc, m_addr, m_instr, m_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_strobe = 0; m_busy = 0; m_stale = 0; m_valid = 0; m_parked = 0;
    m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic model_step();
    bit issue;
    issue = 0;
    if (m_strobe) begin
      m_strobe = 0;
      m_busy   = 1;
      if (redirect_valid) m_stale = 1;
    end else if (m_busy) begin
      if (redirect_valid) m_stale = 1;
      if (!mem_rbusy) begin
        m_busy = 0;
        if (m_stale) begin
          m_stale = 0;
          issue   = 1;
        end else begin
          m_instr = mem_rdata;
          m_pc    = m_pc + 32'd4;
          m_valid = 1;
        end
      end
    end else if (m_valid) begin
      if (instr_ready) m_cnt = m_cnt + 32'd1;
      if (instr_ready || redirect_valid) begin
        m_valid = 0;
        issue   = 1;
      end
    end else if (m_parked) begin
      if (!halt) begin
        m_parked = 0;
        issue    = 1;
      end
    end else begin
      issue = 1;  // first request after reset
    end
    if (redirect_valid) m_pc = redirect_addr;
    if (issue) begin
      if (halt) m_parked = 1;
      else begin
        m_strobe = 1;
        m_addr   = m_pc;
      end
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // Compare process and strobe log
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (mem_rstrb) begin
        st_cyc.push_back(cyc);
        st_addr.push_back(mem_addr);
      end
      chk("mem_rstrb", 32'(mem_rstrb), 32'(m_strobe));
      chk("mem_addr", mem_addr, m_addr);
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("instr", instr, m_instr);
`ifdef FETCH_COUNT_EN
      chk("fetch_count", fetch_count, m_cnt);
`endif
    end
  end

  // Memory and decode environment
  initial begin
    bit          pend;
    int          left;
    int          hcnt;
    logic [31:0] maddr;
    pend = 0; left = 0; hcnt = 0; maddr = 0;
    mem_rbusy = 1; mem_rdata = 0; instr_ready = 1;
    forever begin
      @(negedge clk);
      if (mem_rstrb) begin
        pend      = 1;
        maddr     = mem_addr;
        left      = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
        mem_rbusy = 1'($urandom);
        mem_rdata = $urandom;
      end else if (pend) begin
        if (left > 0) begin
          mem_rbusy = 1;
          mem_rdata = $urandom;
          left--;
        end else begin
          mem_rbusy = 0;
          mem_rdata = mem_word(maddr);
          pend      = 0;
        end
      end else begin
        mem_rbusy = 1'($urandom);
        mem_rdata = $urandom;
      end
      if (lag < 0) begin
        instr_ready = 1'($urandom);
      end else if (instr_valid) begin
        instr_ready = (hcnt >= lag);
        hcnt++;
      end else begin
        instr_ready = 1;
        hcnt        = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_addr.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (st_addr.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (st_addr.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL strobe_timeout: saw %0d strobes, needed %0d", st_addr.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!instr_valid && k < budget) begin
      tick();
      k++;
    end
    if (!instr_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: instr_valid 0, needed 1");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_rstrb"}, 32'(mem_rstrb), 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
`ifdef FETCH_COUNT_EN
    chk({tag, "_count"}, fetch_count, 32'h0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, needed $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rel, mark, vcnt;
    logic [31:0] c0;
    reset = 1; halt = 0; redirect_valid = 0; redirect_addr = 0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rel = cyc;
    clear_log();
    reset = 0;

    // Back-to-back fetches, 1-cycle memory, decode always ready
    wait_strobes(4, 30);
    if (st_addr.size() >= 4) begin
      chk("t1_first_cyc", st_cyc[0], rel + 1);
      chk("t1_addr0", st_addr[0], 32'h0);
      chk("t1_addr1", st_addr[1], 32'h4);
      chk("t1_addr2", st_addr[2], 32'h8);
      chk("t1_gap01", st_cyc[1] - st_cyc[0], 3);
      chk("t1_gap12", st_cyc[2] - st_cyc[1], 3);
      chk("t1_instr", instr, mem_word(32'h8));
`ifdef FETCH_COUNT_EN
      chk("t1_count", fetch_count, 32'd3);
`endif
    end

    // Slow memory plus decode backpressure
    lat = 3; lag = 2;
    clear_log();
    wait_strobes(3, 40);
    if (st_addr.size() >= 3) begin
      chk("t2_gap", st_cyc[2] - st_cyc[1], 8);
      chk("t2_step", st_addr[2] - st_addr[1], 32'h4);
    end

    // Redirect during WAIT, old response arrives the next cycle
    lat = 1; lag = 0;
    clear_log();
    wait_strobes(1, 40);
    tick();
    redirect_valid = 1; redirect_addr = 32'h100;
    tick();
    redirect_valid = 0;
    clear_log();
    vcnt = 0;
    for (int k = 0; k < 10 && st_addr.size() == 0; k++) begin
      if (instr_valid) vcnt++;
      tick();
    end
    chk("t3_no_valid", vcnt, 0);
    wait_strobes(1, 5);
    if (st_addr.size() >= 1) chk("t3_addr", st_addr[0], 32'h100);

    // Redirect coinciding with accept
    lat = 0;
    wait_valid(20);
    c0 = m_cnt;
    mark = cyc;
    redirect_valid = 1; redirect_addr = 32'h40;
    clear_log();
    tick();
    redirect_valid = 0;
`ifdef FETCH_COUNT_EN
    chk("t4_count", fetch_count, c0 + 32'd1);
`else
    chk("t4_model_count", m_cnt, c0 + 32'd1);
`endif
    wait_strobes(1, 5);
    if (st_addr.size() >= 1) begin
      chk("t4_addr", st_addr[0], 32'h40);
      chk("t4_cyc", st_cyc[0], mark + 1);
    end

    // Halt across an accept
    wait_valid(10);
    halt = 1;
    tick();
    clear_log();
    repeat (5) tick();
    chk("t5_quiet", st_addr.size(), 0);
    halt = 0;
    mark = cyc;
    wait_strobes(1, 5);
    if (st_addr.size() >= 1) begin
      chk("t5_addr", st_addr[0], 32'h44);
      chk("t5_cyc", st_cyc[0], mark + 1);
    end

    // PC wrap at the top of the address space
    wait_valid(10);
    redirect_valid = 1; redirect_addr = 32'hFFFF_FFFC;
    clear_log();
    tick();
    redirect_valid = 0;
    wait_strobes(2, 20);
    if (st_addr.size() >= 2) begin
      chk("t6_addr_top", st_addr[0], 32'hFFFF_FFFC);
      chk("t6_addr_wrap", st_addr[1], 32'h0);
    end

    // Reset in the middle of WAIT
    lat = 3;
    clear_log();
    wait_strobes(1, 20);
    tick();
    tick();
    reset = 1;
    #1;
    chk_reset_outputs("t7");
    tick();
    tick();
    reset = 0;
    mark = cyc;
    clear_log();
    wait_strobes(1, 5);
    if (st_addr.size() >= 1) begin
      chk("t7_addr", st_addr[0], 32'h0);
      chk("t7_cyc", st_cyc[0], mark + 1);
    end

    // Randomized traffic
    lat = -1; lag = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) reset = 0;
      else if ($urandom_range(0, 499) == 0) reset = 1;
      if (halt) halt = ($urandom_range(0, 3) != 0);
      else      halt = ($urandom_range(0, 31) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_addr = 32'hFFFF_FFFC;
        1:       redirect_addr = $urandom;
        default: redirect_addr = {$urandom_range(0, 255), 2'b00};
      endcase
    end
    reset = 0; halt = 0; redirect_valid = 0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
